// File: rtl/vc_credit_manager.sv
// Per-port/per-VC credit counters with an upstream credit advertisement sequence after reset.
// Optional error detection enabled by defining VC_CREDIT_ERR_CHK_EN.
module vc_credit_manager #(
    parameter int NUM_PORTS  = 5,
    parameter int NUM_VC     = 2,
    parameter int FIFO_DEPTH = 8,
    parameter int RET_LAT    = 1
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic [NUM_PORTS*NUM_VC-1:0] ds_credit,
    input  logic [NUM_PORTS*NUM_VC-1:0] flit_sent,
    input  logic [NUM_PORTS*NUM_VC-1:0] buf_release,
    output logic [NUM_PORTS*NUM_VC-1:0] can_send,
    output logic [NUM_PORTS*NUM_VC-1:0] upstream_credit,
    output logic                        init_done,
    output logic [NUM_PORTS*NUM_VC-1:0] err_overflow,
    output logic [NUM_PORTS*NUM_VC-1:0] err_underflow,
    output logic                        err_proto
);

    localparam int L  = NUM_PORTS * NUM_VC;
    localparam int CW = $clog2(FIFO_DEPTH + 1);
    localparam logic [CW-1:0] CNT_MAX  = CW'(FIFO_DEPTH);
    localparam logic [CW-1:0] INIT_END = CW'(FIFO_DEPTH - 1);

    typedef enum logic {ST_INIT, ST_RUN} state_t;

    state_t        state_reg, state_next;
    logic [CW-1:0] init_cnt_reg, init_cnt_next;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg    <= ST_INIT;
            init_cnt_reg <= '0;
        end else begin
            state_reg    <= state_next;
            init_cnt_reg <= init_cnt_next;
        end
    end

    always_comb begin
        state_next    = state_reg;
        init_cnt_next = init_cnt_reg;
        case (state_reg)
            ST_INIT: begin
                init_cnt_next = init_cnt_reg + CW'(1);
                if (init_cnt_reg == INIT_END) begin
                    state_next = ST_RUN;
                end
            end
            default: state_next = ST_RUN;
        endcase
    end

    assign init_done = (state_reg == ST_RUN);

    // During INIT every lane advertises one credit per cycle; releases are dropped.
    logic [L-1:0] ret_in;
    logic [L-1:0] ret_pipe_reg [RET_LAT];

    assign ret_in = (state_reg == ST_INIT) ? {L{1'b1}} : buf_release;

    genvar gi;
    generate
        for (gi = 0; gi < RET_LAT; gi++) begin : g_ret
            if (gi == 0) begin : g_first
                always_ff @(posedge clk) begin
                    if (rst) ret_pipe_reg[gi] <= '0;
                    else     ret_pipe_reg[gi] <= ret_in;
                end
            end else begin : g_rest
                always_ff @(posedge clk) begin
                    if (rst) ret_pipe_reg[gi] <= '0;
                    else     ret_pipe_reg[gi] <= ret_pipe_reg[gi-1];
                end
            end
        end
    endgenerate

    assign upstream_credit = ret_pipe_reg[RET_LAT-1];

    // Saturating per-lane credit counters; simultaneous +1/-1 cancel.
    logic [CW-1:0] cnt_reg [L];
    logic [L-1:0]  inc_only;
    logic [L-1:0]  dec_only;

    generate
        for (gi = 0; gi < L; gi++) begin : g_lane
            assign inc_only[gi] = ds_credit[gi] & ~flit_sent[gi];
            assign dec_only[gi] = flit_sent[gi] & ~ds_credit[gi];

            always_ff @(posedge clk) begin
                if (rst) begin
                    cnt_reg[gi] <= '0;
                end else if (inc_only[gi] && (cnt_reg[gi] != CNT_MAX)) begin
                    cnt_reg[gi] <= cnt_reg[gi] + CW'(1);
                end else if (dec_only[gi] && (cnt_reg[gi] != '0)) begin
                    cnt_reg[gi] <= cnt_reg[gi] - CW'(1);
                end
            end

            assign can_send[gi] = (cnt_reg[gi] != '0);
        end
    endgenerate

`ifdef VC_CREDIT_ERR_CHK_EN
    logic [L-1:0] ovf_hit;
    logic [L-1:0] unf_hit;
    logic [L-1:0] ovf_reg;
    logic [L-1:0] unf_reg;
    logic         proto_reg;

    generate
        for (gi = 0; gi < L; gi++) begin : g_err
            assign ovf_hit[gi] = inc_only[gi] && (cnt_reg[gi] == CNT_MAX);
            assign unf_hit[gi] = dec_only[gi] && (cnt_reg[gi] == '0);
        end
    endgenerate

    always_ff @(posedge clk) begin
        if (rst) begin
            ovf_reg   <= '0;
            unf_reg   <= '0;
            proto_reg <= 1'b0;
        end else begin
            ovf_reg   <= ovf_reg | ovf_hit;
            unf_reg   <= unf_reg | unf_hit;
            proto_reg <= proto_reg | ((state_reg == ST_INIT) && (|buf_release));
        end
    end

    assign err_overflow  = ovf_reg;
    assign err_underflow = unf_reg;
    assign err_proto     = proto_reg;
`else
    assign err_overflow  = '0;
    assign err_underflow = '0;
    assign err_proto     = 1'b0;
`endif

endmodule

// File: tb/tb_vc_credit_manager.sv
// Directed bench for vc_credit_manager with a per-cycle behavioural model check.
module tb_vc_credit_manager;

    localparam int NP = 5;
    localparam int NV = 2;
    localparam int FD = 8;
    localparam int RL = 1;
    localparam int L  = NP * NV;
`ifdef VC_CREDIT_ERR_CHK_EN
    localparam bit ERR_EN = 1'b1;
`else
    localparam bit ERR_EN = 1'b0;
`endif

    logic         clk = 1'b0;
    logic         rst = 1'b1;
    logic [L-1:0] ds_credit   = '0;
    logic [L-1:0] flit_sent   = '0;
    logic [L-1:0] buf_release = '0;
    logic [L-1:0] can_send;
    logic [L-1:0] upstream_credit;
    logic         init_done;
    logic [L-1:0] err_overflow;
    logic [L-1:0] err_underflow;
    logic         err_proto;

    int n_tests = 0;
    int n_fail  = 0;

    vc_credit_manager #(
        .NUM_PORTS (NP),
        .NUM_VC    (NV),
        .FIFO_DEPTH(FD),
        .RET_LAT   (RL)
    ) dut (
        .clk            (clk),
        .rst            (rst),
        .ds_credit      (ds_credit),
        .flit_sent      (flit_sent),
        .buf_release    (buf_release),
        .can_send       (can_send),
        .upstream_credit(upstream_credit),
        .init_done      (init_done),
        .err_overflow   (err_overflow),
        .err_underflow  (err_underflow),
        .err_proto      (err_proto)
    );

    always #5 clk = ~clk;

    // Behavioural model: integer credit balances, edge count since reset, queue of advertised credits.
    int           m_cnt [L];
    int           m_edges;
    bit           m_valid = 1'b0;
    logic [L-1:0] m_ovf, m_unf;
    logic         m_proto;
    logic [L-1:0] m_retq [$];

    always @(posedge clk) begin
        if (rst) begin
            foreach (m_cnt[i]) m_cnt[i] = 0;
            m_edges = 0;
            m_ovf   = '0;
            m_unf   = '0;
            m_proto = 1'b0;
            m_retq.delete();
            m_valid = 1'b1;
        end else begin
            for (int i = 0; i < L; i++) begin
                if (ds_credit[i] && !flit_sent[i]) begin
                    if (m_cnt[i] == FD) m_ovf[i] = 1'b1;
                    else m_cnt[i]++;
                end else if (flit_sent[i] && !ds_credit[i]) begin
                    if (m_cnt[i] == 0) m_unf[i] = 1'b1;
                    else m_cnt[i]--;
                end
            end
            if (m_edges < FD) begin
                if (|buf_release) m_proto = 1'b1;
                m_retq.push_back({L{1'b1}});
            end else begin
                m_retq.push_back(buf_release);
            end
            if (m_retq.size() > RL) void'(m_retq.pop_front());
            m_edges++;
        end
    end

    function automatic logic [L-1:0] exp_can();
        logic [L-1:0] v = '0;
        for (int i = 0; i < L; i++) v[i] = (m_cnt[i] != 0);
        return v;
    endfunction

    task automatic cmp(input string name, input logic [L-1:0] act, input logic [L-1:0] req);
        n_tests++;
        if (act !== req) begin
            n_fail++;
            $display("FAIL %s: actual %h required %h at %0t", name, act, req, $time);
        end
    endtask

    always @(negedge clk) begin
        if (m_valid) begin
            cmp("can_send", can_send, exp_can());
            cmp("upstream_credit", upstream_credit,
                (m_retq.size() == RL) ? m_retq[0] : '0);
            cmp("init_done", L'(init_done), L'(m_edges >= FD));
            cmp("err_overflow", err_overflow, ERR_EN ? m_ovf : '0);
            cmp("err_underflow", err_underflow, ERR_EN ? m_unf : '0);
            cmp("err_proto", L'(err_proto), L'(ERR_EN & m_proto));
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        tick();
        tick();
        cmp("lit_reset_can", can_send, '0);
        cmp("lit_reset_up", upstream_credit, '0);
        cmp("lit_reset_done", L'(init_done), '0);
        rst = 1'b0;

        // Advertisement after reset release.
        for (int n = 1; n <= 10; n++) begin
            tick();
            cmp("lit_adv_up", upstream_credit, (n <= FD) ? 10'h3FF : 10'h000);
            cmp("lit_adv_done", L'(init_done), L'(n >= FD));
        end
        $display("[TB] txn: advertisement after reset");

        // Lane 4: three credits, three sends.
        ds_credit = 10'h010;
        tick();
        cmp("lit_l4_first", can_send, 10'h010);
        tick();
        tick();
        ds_credit = '0;
        flit_sent = 10'h010;
        tick();
        tick();
        cmp("lit_l4_two_sent", can_send, 10'h010);
        tick();
        flit_sent = '0;
        cmp("lit_l4_drained", can_send, 10'h000);
        $display("[TB] txn: lane 4 credit/send");

        // Lane 0 to 5, then simultaneous credit+send for 4 cycles.
        ds_credit = 10'h001;
        repeat (5) tick();
        flit_sent = 10'h001;
        repeat (4) tick();
        ds_credit = '0;
        flit_sent = 10'h001;
        repeat (4) tick();
        flit_sent = '0;
        cmp("lit_l0_cancel", L'(can_send[0]), L'(1));
        $display("[TB] txn: lane 0 simultaneous credit and send");

        // Lane 7 saturation, then 8 sends empty it.
        ds_credit = 10'h080;
        repeat (9) tick();
        ds_credit = '0;
        cmp("lit_l7_ovf", L'(err_overflow[7]), L'(ERR_EN));
        flit_sent = 10'h080;
        repeat (7) tick();
        cmp("lit_l7_one_left", L'(can_send[7]), L'(1));
        tick();
        cmp("lit_l7_empty", L'(can_send[7]), L'(0));
        flit_sent = 10'h004;
        tick();
        flit_sent = '0;
        cmp("lit_l2_unf", L'(err_underflow[2]), L'(ERR_EN));
        $display("[TB] txn: lane 7 saturation, lane 2 underflow");

        // Credit return in RUN.
        buf_release = 10'h201;
        tick();
        buf_release = '0;
        cmp("lit_ret_pulse", upstream_credit, 10'h201);
        tick();
        cmp("lit_ret_clear", upstream_credit, 10'h000);
        $display("[TB] txn: run-mode credit return");

        // Reset mid-traffic, with releases during INIT.
        ds_credit = 10'h008;
        tick();
        tick();
        ds_credit = '0;
        cmp("lit_l3_loaded", L'(can_send[3]), L'(1));
        rst = 1'b1;
        tick();
        cmp("lit_rst_can", can_send, '0);
        cmp("lit_rst_ovf", err_overflow, '0);
        cmp("lit_rst_unf", err_underflow, '0);
        cmp("lit_rst_done", L'(init_done), '0);
        rst = 1'b0;
        buf_release = 10'h201;
        for (int n = 1; n <= 10; n++) begin
            tick();
            if (n == 2) buf_release = '0;
            cmp("lit_readv_up", upstream_credit, (n <= FD) ? 10'h3FF : 10'h000);
            cmp("lit_readv_done", L'(init_done), L'(n >= FD));
        end
        cmp("lit_proto", L'(err_proto), L'(ERR_EN));
        $display("[TB] txn: reset mid-traffic and re-advertisement");

        @(negedge clk);
        #1;
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/vc_credit_manager.md
# vc_credit_manager

Per-port, per-virtual-channel credit manager for the router output stage, generalising single-VC credit tracking to `NUM_VC` channels. It counts credits advertised by downstream routers and gates `can_send` per port/VC. After every reset it advertises this router's input-buffer credits upstream through an initialisation sequence, then returns credits as buffer slots free. It sits between the output arbiter/queues and the link interface.

## Interface
- `NUM_PORTS`, 5, number of router ports
- `NUM_VC`, 2, virtual channels per port
- `FIFO_DEPTH`, 8, flit slots per VC buffer (local and downstream, both sides); ≥1
- `RET_LAT`, 1, register stages on the upstream credit return path; ≥1
- Lane index: `i = port*NUM_VC + vc` for every vector below (width `L = NUM_PORTS*NUM_VC`)
- `clk`  in  1  clock
- `rst`  in  1  **reset rst, synchronous, active-high; clock clk**
- `ds_credit`  in  L  credit received from downstream for lane i (+1)
- `flit_sent`  in  L  flit launched on lane i (−1)
- `buf_release`  in  L  local input-buffer slot freed on lane i
- `can_send`  out  L  lane i holds ≥1 credit
- `upstream_credit`  out  L  credit pulse to upstream router
- `init_done`  out  1  initialisation advertisement complete
- `err_overflow`  out  L  sticky: credit count would exceed FIFO_DEPTH
- `err_underflow`  out  L  sticky: flit sent with zero credits
- `err_proto`  out  1  sticky: buf_release asserted during INIT

## Operation
- Counter width `CW = $clog2(FIFO_DEPTH+1)`; one counter per lane; reset value 0 (credits come only from downstream advertisement).
- Per lane per cycle: ds_credit only → +1; flit_sent only → −1; both or neither → unchanged.
- Saturation: +1 at FIFO_DEPTH holds value; −1 at 0 holds value (never wraps).
- `can_send[i] = (cnt[i] != 0)`, combinational from counter register; independent of FSM state.
- FSM, one instance: INIT → RUN.
  - INIT (reset state, `init_cnt = 0`): return-pipeline input forced to all-ones; `init_cnt` increments each non-reset cycle; leaves after FIFO_DEPTH cycles in INIT.
  - RUN: return-pipeline input = `buf_release`; terminal state until `rst`.
- buf_release in INIT is dropped (no upstream credit ever produced for it).
- `init_done = (state == RUN)`.
- rst at any time: counters 0, pipeline cleared, FSM to INIT, `init_cnt` 0, error flags cleared; the advertisement sequence repeats.

## Timing
- Reset values: `can_send` 0, `upstream_credit` 0, `init_done` 0, all error flags 0.
- Edge 1 = first rising edge with rst low. `upstream_credit` is all-ones from RET_LAT−1 cycles after edge 1 for exactly FIFO_DEPTH consecutive cycles; with RET_LAT=1 it is high after edges 1..FIFO_DEPTH.
- `init_done` rises after edge FIFO_DEPTH.
- In RUN, `upstream_credit[i]` = `buf_release[i]` delayed RET_LAT cycles, one pulse per event, no merging or loss.
- Counter update visible on `can_send` the cycle after the event edge; send with count 1 drops `can_send` next cycle.
- Lanes are fully independent; every lane may update in the same cycle.

## Configuration
- `VC_CREDIT_ERR_CHK_EN` defined: error flags set on the event edge and sticky until rst. Overflow is +1 at FIFO_DEPTH with no concurrent −1. Underflow is −1 at 0 with no concurrent +1. err_proto is buf_release during INIT.
- Undefined: `err_overflow`, `err_underflow`, `err_proto` tied to 0 and no detection logic. Saturation and drop behaviour unchanged.

## Test plan
All scenarios use NUM_PORTS=5, NUM_VC=2, FIFO_DEPTH=8, RET_LAT=1.
- Reset release, no traffic → `upstream_credit` = 10'h3FF for exactly 8 cycles, then 0. `init_done` high from cycle 9 on. `can_send` = 0.
- 3 `ds_credit` pulses on lane 4, then 3 `flit_sent` → `can_send[4]` high after the first pulse; low the cycle after the third send. Other lanes unaffected.
- Lane 0 at count 5, `ds_credit` and `flit_sent` asserted together for 4 cycles → count stays 5, `can_send[0]` stays 1.
- 9 `ds_credit` pulses on lane 7 → count saturates at 8. With `VC_CREDIT_ERR_CHK_EN`, `err_overflow[7]` = 1 after the 9th pulse. `flit_sent` on lane 2 at 0 → `err_underflow[2]` = 1.
- In RUN, `buf_release` = 10'b1000000001 for one cycle → `upstream_credit` = 10'b1000000001 exactly one cycle later. During INIT the same stimulus → no extra pulse, `err_proto` = 1 (macro defined).
- `rst` pulsed mid-traffic with lane counts nonzero → all counts 0, flags cleared. The 8-cycle advertisement restarts, and `init_done` is low until it completes.
